// File: rtl/avg_seq_ctrl.sv
// Averages num_l unsigned samples through one shared adder, then a restoring divider.
// Latency: avg_valid in the cycle after edge k+SUMW+1 (k = edge taking the last sample).
module avg_seq_ctrl #(
   parameter int DATAWIDTH = 16,
   parameter int MAXN      = 8,
   parameter int CNTW      = 4,
   parameter int SUMW      = 19
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [CNTW-1:0]      num,
   input  logic                 in_valid,
   input  logic [DATAWIDTH-1:0] in_data,
   output logic                 in_ready,
   output logic                 busy,
   output logic [DATAWIDTH-1:0] avg,
   output logic                 avg_valid,
   output logic                 err
);

   localparam int BW = $clog2(SUMW + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

   state_t               state_q, state_d;
   logic [SUMW-1:0]      acc_q, acc_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic [CNTW-1:0]      num_l_q, num_l_d;
   logic [CNTW:0]        rem_q, rem_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATAWIDTH-1:0] avg_q, avg_d;
   logic                 avg_valid_q, avg_valid_d;
   logic                 err_q, err_d;
   logic [CNTW+1:0]      rem_sh;
   logic                 q_bit;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         num_l_q     <= '0;
         rem_q       <= '0;
         bit_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         num_l_q     <= num_l_d;
         rem_q       <= rem_d;
         bit_q       <= bit_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      num_l_d     = num_l_q;
      rem_d       = rem_q;
      bit_d       = bit_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      err_d       = 1'b0;
      rem_sh      = {rem_q, acc_q[SUMW-1]};
      q_bit       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num != '0 && num <= CNTW'(MAXN)) begin
                  num_l_d = num;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ACCUM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_d = acc_q + SUMW'(in_data);
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == num_l_q - CNTW'(1)) begin
                  rem_d   = '0;
                  bit_d   = '0;
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            // acc doubles as the dividend shifting out and the quotient shifting in
            if (rem_sh >= (CNTW+2)'(num_l_q)) begin
               q_bit = 1'b1;
               rem_d = (CNTW+1)'(rem_sh - (CNTW+2)'(num_l_q));
            end else begin
               rem_d = (CNTW+1)'(rem_sh);
            end
            acc_d = {acc_q[SUMW-2:0], q_bit};
            bit_d = bit_q + BW'(1);
            if (bit_q == BW'(SUMW - 1)) state_d = DONE;
         end
         DONE: begin
            avg_d       = acc_q[DATAWIDTH-1:0];
            avg_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == ACCUM);
   assign busy      = (state_q != IDLE);
   assign avg       = avg_q;
   assign avg_valid = avg_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Scoreboard bench for avg_seq_ctrl: directed vectors push expected results, a monitor checks them.
module tb_avg_seq_ctrl;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  num = '0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, busy, avg_valid, err;
   logic [15:0] avg;

   typedef struct {
      logic [15:0] avg;
      int          edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   edge_cnt = 0;
   int   err_seen = 0;
   int   exp_err = 0;

   avg_seq_ctrl dut (
      .Clk(Clk), .Rst(Rst), .start(start), .num(num),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .busy(busy), .avg(avg), .avg_valid(avg_valid), .err(err)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every avg_valid strobe must match the oldest expected result and its edge.
   always @(negedge Clk) begin
      if (err === 1'b1) err_seen++;
      if (avg_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_avg_valid", 32'(avg), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("avg_value", 32'(avg), 32'(e.avg));
            chk("avg_latency_edge", 32'(edge_cnt), 32'(e.edge_no));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] n);
      start = 1'b1;
      num   = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] d, input bit last_s, input logic [15:0] exp_avg);
      exp_t e;
      int   waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      if (in_ready !== 1'b1) begin
         chk("in_ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      tick();
      in_valid = 1'b0;
      if (last_s) begin
         e.avg     = exp_avg;
         e.edge_no = edge_cnt + 20;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_avg", 32'(avg), 32'd0);
      chk("rst_avg_valid", 32'(avg_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      Rst = 1'b0;
      tick();

      // T1: 1..8 back-to-back, sum 36, avg 4
      do_start(4'd8);
      for (int i = 1; i <= 8; i++) send(16'(i), i == 8, 16'd4);
      wait_drain();

      // T2: full-scale samples must not wrap
      do_start(4'd8);
      for (int i = 0; i < 8; i++) send(16'hFFFF, i == 7, 16'hFFFF);
      wait_drain();

      // T3: gaps of two idle cycles, sum 61 / 3 = 20
      do_start(4'd3);
      send(16'd10, 1'b0, 16'd0);
      repeat (2) begin tick(); chk("t3_ready_in_gap", 32'(in_ready), 32'd1); end
      send(16'd20, 1'b0, 16'd0);
      repeat (2) begin tick(); chk("t3_ready_in_gap", 32'(in_ready), 32'd1); end
      send(16'd31, 1'b1, 16'd20);
      wait_drain();

      // T4: illegal counts are rejected with one err pulse each
      do_start(4'd0);
      exp_err++;
      chk("t4_err_num0", 32'(err), 32'd1);
      tick();
      chk("t4_err_one_cycle", 32'(err), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      do_start(4'd9);
      exp_err++;
      chk("t4_err_num9", 32'(err), 32'd1);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_busy2", 32'(busy), 32'd0);
      tick();
      chk("t4_avg_held", 32'(avg), 32'd20);

      // T5: start pulses while busy have no effect
      do_start(4'd8);
      for (int i = 1; i <= 4; i++) send(16'(i), 1'b0, 16'd0);
      do_start(4'd0);
      chk("t5_busy_accum", 32'(busy), 32'd1);
      for (int i = 5; i <= 8; i++) send(16'(i), i == 8, 16'd4);
      tick();
      do_start(4'd0);
      do_start(4'd3);
      chk("t5_busy_div", 32'(busy), 32'd1);
      chk("t5_no_err", 32'(err), 32'd0);
      wait_drain();

      // T6: reset mid-divide aborts, then a single-sample average
      do_start(4'd4);
      for (int i = 0; i < 4; i++) send(16'h0100, 1'b0, 16'd0);
      repeat (5) tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk("t6_avg", 32'(avg), 32'd0);
      chk("t6_avg_valid", 32'(avg_valid), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_in_ready", 32'(in_ready), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      repeat (25) tick();
      do_start(4'd1);
      send(16'h1234, 1'b1, 16'h1234);
      wait_drain();

      chk("err_pulse_count", 32'(err_seen), 32'(exp_err));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
